// File: rtl/ppu_oam_dma_if.sv
// Bus bundle between the CPU core / memory map and the $4014 sprite DMA engine.
// master = DMA engine (snoops CPU, drives DMA bus); slave = CPU side / bus mux.
interface ppu_oam_dma_if;
    logic [15:0] cpumc_a_in;
    logic [7:0]  cpumc_din;
    logic        cpumc_r_nw_in;
    logic        active_out;
    logic [15:0] cpumc_a_out;
    logic [7:0]  cpumc_d_out;
    logic        cpumc_r_nw_out;

    modport master (
        input  cpumc_a_in, cpumc_din, cpumc_r_nw_in,
        output active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out
    );

    modport slave (
        output cpumc_a_in, cpumc_din, cpumc_r_nw_in,
        input  active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out
    );
endinterface

// File: rtl/ppu_oam_dma.sv
// $4014 sprite DMA: copies CPU page $P00-$PFF into OAM through $2004 writes.
// Define PPU_OAM_DMA_ALIGN_EN to insert one ALIGN cycle when a transfer starts on odd parity.
module ppu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input logic           clk_in,
    input logic           rst_in,
    ppu_oam_dma_if.master bus
);

`ifdef PPU_OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, START, ALIGN, READ, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
`endif

    state_t      state_reg;
    logic [7:0]  page_reg;
    logic [7:0]  idx_reg;
    logic [7:0]  data_reg;
    logic        active_reg;
    logic [15:0] addr_reg;
    logic        r_nw_reg;

`ifdef PPU_OAM_DMA_ALIGN_EN
    logic parity_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) parity_reg <= 1'b0;
        else        parity_reg <= ~parity_reg;
    end
`endif

    // Every output is a flop; the next-cycle bus values are loaded on each transition.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            page_reg   <= 8'h00;
            idx_reg    <= 8'h00;
            data_reg   <= 8'h00;
            active_reg <= 1'b0;
            addr_reg   <= 16'h0000;
            r_nw_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Trigger only evaluated here, so DMA's own writes can never retrigger.
                    if (!bus.cpumc_r_nw_in && bus.cpumc_a_in == DMA_REG_ADDR) begin
                        page_reg   <= bus.cpumc_din;
                        idx_reg    <= 8'h00;
                        state_reg  <= START;
                        active_reg <= 1'b1;
                        addr_reg   <= 16'h0000;
                        r_nw_reg   <= 1'b1;
                    end
                end
                START: begin
`ifdef PPU_OAM_DMA_ALIGN_EN
                    if (parity_reg) begin
                        state_reg <= ALIGN;
                    end else begin
                        state_reg <= READ;
                        addr_reg  <= {page_reg, idx_reg};
                    end
`else
                    state_reg <= READ;
                    addr_reg  <= {page_reg, idx_reg};
`endif
                end
`ifdef PPU_OAM_DMA_ALIGN_EN
                ALIGN: begin
                    state_reg <= READ;
                    addr_reg  <= {page_reg, idx_reg};
                end
`endif
                READ: begin
                    data_reg  <= bus.cpumc_din;
                    state_reg <= WRITE;
                    addr_reg  <= OAM_DATA_ADDR;
                    r_nw_reg  <= 1'b0;
                end
                WRITE: begin
                    r_nw_reg <= 1'b1;
                    if (idx_reg == 8'hFF) begin
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                        addr_reg   <= 16'h0000;
                    end else begin
                        // idx wraps in 8 bits; page is never carried into.
                        idx_reg   <= idx_reg + 8'd1;
                        state_reg <= READ;
                        addr_reg  <= {page_reg, idx_reg + 8'd1};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.active_out     = active_reg;
    assign bus.cpumc_a_out    = addr_reg;
    assign bus.cpumc_d_out    = data_reg;
    assign bus.cpumc_r_nw_out = r_nw_reg;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: CPU/memory model, OAM model, per-transfer report lines.
module tb_ppu_oam_dma;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] cpu_din;

    always #5 clk_in = ~clk_in;

    ppu_oam_dma_if bus ();

    ppu_oam_dma dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Memory contents: page 2 gives i ^ 8'h5A.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    assign bus.cpumc_din = bus.active_out ? mem_byte(bus.cpumc_a_out) : cpu_din;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          edge_cnt;
    int          active_cnt, rd_cnt, wr_cnt, rd_bad, wr_bad, first_rd_at, idle_bad;
    logic [15:0] last_rd_addr;
    logic [7:0]  cur_page;
    logic [7:0]  oam [256];

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk_in) begin
        if (!rst_in && bus.active_out) begin
            if (bus.cpumc_r_nw_out) begin
                if (bus.cpumc_a_out != 16'h0000) begin
                    if (rd_cnt == 0) first_rd_at = active_cnt;
                    if (bus.cpumc_a_out != {cur_page, rd_cnt[7:0]}) rd_bad++;
                    last_rd_addr = bus.cpumc_a_out;
                    rd_cnt++;
                end
            end else begin
                if (bus.cpumc_a_out != 16'h2004) wr_bad++;
                if (wr_cnt < 256) oam[wr_cnt] = bus.cpumc_d_out;
                wr_cnt++;
            end
            active_cnt++;
        end
        if (!rst_in && !bus.active_out &&
            (bus.cpumc_a_out != 16'h0000 || bus.cpumc_r_nw_out != 1'b1)) idle_bad++;
    end

    task automatic clear_stats(input logic [7:0] page);
        active_cnt   = 0;
        rd_cnt       = 0;
        wr_cnt       = 0;
        rd_bad       = 0;
        wr_bad       = 0;
        first_rd_at  = -1;
        last_rd_addr = 16'h0000;
        cur_page     = page;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    endtask

    // One CPU write; par returns the DUT parity seen in the START cycle.
    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data,
                             input bit force_odd, output bit par);
        @(negedge clk_in);
        if (force_odd && edge_cnt[0]) @(negedge clk_in);
        bus.cpumc_a_in    = addr;
        bus.cpumc_r_nw_in = 1'b0;
        cpu_din           = data;
        @(posedge clk_in);
        #1;
        par               = edge_cnt[0];
        bus.cpumc_r_nw_in = 1'b1;
        bus.cpumc_a_in    = 16'h1234;
    endtask

    task automatic run_dma(input string tag, input logic [7:0] page,
                           input bit retrig, input bit force_odd, output bit par);
        int k;
        int exp_len;
        int exp_first;
        int oam_bad;
        clear_stats(page);
        cpu_write(16'h4014, page, force_odd, par);
        check({tag, "_act_latency"}, bus.active_out, 1'b1);
`ifdef PPU_OAM_DMA_ALIGN_EN
        exp_len   = par ? 514 : 513;
        exp_first = par ? 2 : 1;
`else
        exp_len   = 513;
        exp_first = 1;
`endif
        k = 0;
        while (k < 1200) begin
            @(negedge clk_in);
            if (retrig && k == 100) begin
                bus.cpumc_a_in    = 16'h4014;
                bus.cpumc_r_nw_in = 1'b0;
                cpu_din           = 8'h07;
            end
            if (retrig && k == 101) begin
                bus.cpumc_a_in    = 16'h1234;
                bus.cpumc_r_nw_in = 1'b1;
            end
            if (active_cnt > 0 && !bus.active_out) break;
            k++;
        end
        check({tag, "_done"}, k < 1200, 1'b1);
        oam_bad = 0;
        for (int i = 0; i < 256; i++)
            if (oam[i] !== (i[7:0] ^ page ^ 8'h58)) oam_bad++;
        check({tag, "_active_len"}, active_cnt, exp_len);
        check({tag, "_first_rd"}, first_rd_at, exp_first);
        check({tag, "_reads"}, rd_cnt, 256);
        check({tag, "_writes"}, wr_cnt, 256);
        check({tag, "_rd_order"}, rd_bad, 0);
        check({tag, "_wr_addr"}, wr_bad, 0);
        check({tag, "_oam"}, oam_bad, 0);
        check({tag, "_last_rd"}, last_rd_addr, {page, 8'hFF});
        check({tag, "_idle_a"}, bus.cpumc_a_out, 16'h0000);
        check({tag, "_idle_rnw"}, bus.cpumc_r_nw_out, 1'b1);
        $display("dma %s page=%02h parity=%0d active=%0d reads=%0d writes=%0d last=%04h",
                 tag, page, par, active_cnt, rd_cnt, wr_cnt, last_rd_addr);
    endtask

    initial begin : main
        bit par;
        logic [15:0] idle_addrs [4];
        int k;
        idle_addrs[0] = 16'h4015;
        idle_addrs[1] = 16'h2004;
        idle_addrs[2] = 16'h4013;
        idle_addrs[3] = 16'h4014;

        rst_in            = 1'b1;
        bus.cpumc_a_in    = 16'h1234;
        bus.cpumc_r_nw_in = 1'b1;
        cpu_din           = 8'h00;
        idle_bad          = 0;
        clear_stats(8'h00);
        repeat (3) @(negedge clk_in);
        check("rst_active", bus.active_out, 1'b0);
        check("rst_a", bus.cpumc_a_out, 16'h0000);
        check("rst_d", bus.cpumc_d_out, 8'h00);
        check("rst_rnw", bus.cpumc_r_nw_out, 1'b1);
        rst_in = 1'b0;

        // Idle traffic; $4014 is only ever read here.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            bus.cpumc_a_in    = idle_addrs[i % 4];
            bus.cpumc_r_nw_in = (idle_addrs[i % 4] == 16'h4014) ? 1'b1 : 1'(i % 2);
            cpu_din           = 8'(i * 7);
        end
        @(negedge clk_in);
        bus.cpumc_r_nw_in = 1'b1;
        bus.cpumc_a_in    = 16'h1234;
        check("idle_active_cycles", active_cnt, 0);
        check("idle_bus", idle_bad, 0);
        $display("idle 20 cycles active=%0d", active_cnt);

        run_dma("p02", 8'h02, 1'b0, 1'b0, par);
        check("p02_oam_first", oam[0], 8'h5A);
        check("p02_oam_40", oam[8'h40], 8'h1A);
        check("p02_oam_last", oam[255], 8'hA5);

        run_dma("pFF", 8'hFF, 1'b0, 1'b0, par);

        // Reset in the WRITE cycle of idx 8'h40.
        clear_stats(8'h05);
        cpu_write(16'h4014, 8'h05, 1'b0, par);
        k = 0;
        while (k < 1000) begin
            @(negedge clk_in);
            if (!bus.cpumc_r_nw_out && last_rd_addr == 16'h0540) break;
            k++;
        end
        check("abort_reached", k < 1000, 1'b1);
        #2 rst_in = 1'b1;
        #1;
        check("abort_active", bus.active_out, 1'b0);
        check("abort_a", bus.cpumc_a_out, 16'h0000);
        check("abort_d", bus.cpumc_d_out, 8'h00);
        check("abort_rnw", bus.cpumc_r_nw_out, 1'b1);
        $display("abort page=05 reset at write of idx 40 writes_before=%0d", wr_cnt);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        clear_stats(8'h05);
        repeat (10) @(negedge clk_in);
        check("abort_no_resume", active_cnt, 0);

        run_dma("p03", 8'h03, 1'b0, 1'b0, par);
        run_dma("retrig", 8'h04, 1'b1, 1'b0, par);

        run_dma("odd", 8'h06, 1'b0, 1'b1, par);
        check("odd_parity", par, 1'b1);
`ifdef PPU_OAM_DMA_ALIGN_EN
        check("odd_len_align", active_cnt, 514);
`else
        check("odd_len_plain", active_cnt, 513);
`endif

        check("idle_bus_total", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- CPU-side initiator for the PPU register interface.
- Implements the $4014 sprite DMA: on a CPU write of page P to $4014, it halts the CPU and copies CPU addresses $P00-$PFF into OAM.
- Each byte is written through PPU register $2004 (OAMDATA) using the same bus the CPU uses to drive ri_sel/ri_ncs/ri_r_nw/ri_d.
- Sits between the CPU core and the CPU memory map / bus mux; the PPU sees its accesses as ordinary CPU register writes.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every transferred byte.

Ports:
- clk_in  input  1  system clock, one DMA step per edge.
- rst_in  input  1  reset; asynchronous, active-high.
- cpumc_a_in  input  16  CPU-core address bus (snooped for trigger).
- cpumc_din  input  8  CPU data bus: CPU write data when idle, memory read data during DMA.
- cpumc_r_nw_in  input  1  CPU-core read/write (1=read, 0=write).
- active_out  output  1  high while DMA owns the bus; CPU rdy = ~active_out; bus mux selects DMA outputs.
- cpumc_a_out  output  16  DMA bus address.
- cpumc_d_out  output  8  DMA write data.
- cpumc_r_nw_out  output  1  DMA bus read/write.

Behaviour:
- Fixed clock/reset decision: one clock (clk_in); reset rst_in is asynchronous and active-high.
- Reset values: active_out=0, cpumc_a_out=16'h0000, cpumc_d_out=8'h00, cpumc_r_nw_out=1, state=IDLE, idx=0, page=0, data=0. All outputs are registered.
- Trigger: in IDLE, when cpumc_r_nw_in=0 and cpumc_a_in=DMA_REG_ADDR at a rising edge:
  - capture page<=cpumc_din[7:0] and idx<=0;
  - go to START.
- States:
  - IDLE: outputs at reset values.
  - START: exactly 1 cycle; active_out=1, bus idle (r_nw=1, a=0). Next state is READ, or ALIGN under the optional feature.
  - READ: cpumc_a_out={page,idx}, cpumc_r_nw_out=1. Memory read data is combinational and valid on cpumc_din in this cycle. At the closing edge: data<=cpumc_din; go to WRITE.
  - WRITE: cpumc_a_out=OAM_DATA_ADDR, cpumc_d_out=data, cpumc_r_nw_out=0. At the closing edge:
    - if idx==8'hFF, go to IDLE;
    - else idx<=idx+1 (8-bit) and go to READ.
- Latency: trigger edge -> active_out high next cycle. active_out stays high for 513 cycles (1 START + 256 READ/WRITE pairs), or 514 with alignment.
- Write strobes: exactly 256 writes to OAM_DATA_ADDR, in ascending source order $P00..$PFF. The PPU OAM address auto-increments, so no OAMADDR writes are issued.
- Page $FF: source range $FF00-$FFFF. idx is 8-bit, so there is no carry into page; the transfer still stops after $FFFF.
- Retrigger: writes to DMA_REG_ADDR while not IDLE are ignored. The CPU is halted anyway, and DMA's own writes target OAM_DATA_ADDR.
- When DMA_REG_ADDR equals OAM_DATA_ADDR (misconfiguration), DMA's own writes must still not retrigger, because the trigger is only evaluated in IDLE.
- Reset mid-transfer: immediate return to reset values. A partially written OAM is left as is; the transfer does not resume after reset.
- cpumc_d_out holds its last value outside WRITE. Only the r_nw strobe qualifies it.

Optional Feature:
- Macro: PPU_OAM_DMA_ALIGN_EN.
- Defined:
  - a free-running parity flop toggles every cycle (reset 0);
  - if parity=1 during START, one ALIGN cycle (bus idle, active_out=1) is inserted before the first READ;
  - total active time is 514 cycles on odd starts, 513 on even starts.
- Undefined: no parity flop and no ALIGN state; always 513 cycles.

Test Plan:
- Reset then idle 20 cycles, bus toggling non-trigger addresses -> active_out=0, cpumc_r_nw_out=1, cpumc_a_out=16'h0000 throughout.
- Write 8'h02 to $4014, memory model $0200+i=i^8'h5A -> active_out high for exactly 513 cycles. Reads at $0200..$02FF in order; 256 writes to $2004 with data i^8'h5A; OAM model matches.
- Page 8'hFF trigger -> last read address $FFFF, then return to IDLE. No access to $0000 or above $FFFF.
- Assert rst_in asynchronously mid-WRITE at idx=8'h40 -> outputs reach reset values before the next edge; later trigger with page 8'h03 runs a full 513-cycle transfer from $0300.
- CPU model writes $4014 again while active_out=1 -> ignored; the transfer count stays 256 with the original page.
- Trigger on odd parity with PPU_OAM_DMA_ALIGN_EN defined -> 514 active cycles and first READ 2 cycles after activation. Same stimulus with the macro undefined -> 513 cycles.
